// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units, the CDB arbiter and the result consumers.
// The master drives results and flush; the slave (arbiter) drives ready and the broadcast.
interface cdb_arbiter_if #(
   parameter int NUM_FU = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 3
) ();
   logic                     flush;
   logic [NUM_FU-1:0]        fu_valid;
   logic [NUM_FU*TAG_W-1:0]  fu_tag;
   logic [NUM_FU*DATA_W-1:0] fu_data;
   logic [NUM_FU-1:0]        fu_ready;
   logic                     cdb_valid;
   logic [TAG_W-1:0]         cdb_tag;
   logic [DATA_W-1:0]        cdb_data;
   logic [2:0]               cdb_src;
   logic [3:0]               pend_cnt;

   modport master (
      output flush, fu_valid, fu_tag, fu_data,
      input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pend_cnt
   );

   modport slave (
      input  flush, fu_valid, fu_tag, fu_data,
      output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pend_cnt
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per functional unit, round-robin grant,
// one registered broadcast per cycle.
module cdb_arbiter #(
   parameter int NUM_FU = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 3
) (
   input  logic         clk1,
   input  logic         rst_n,
   cdb_arbiter_if.slave bus
);
   localparam int          IW       = $clog2(NUM_FU);
   localparam logic [IW:0] NUM_FU_W = (IW+1)'(NUM_FU);

   logic [NUM_FU-1:0]              hold_v_q, hold_v_d;
   logic [NUM_FU-1:0][TAG_W-1:0]   hold_tag_q, hold_tag_d;
   logic [NUM_FU-1:0][DATA_W-1:0]  hold_data_q, hold_data_d;
   logic [IW-1:0]                  rr_ptr_q, rr_ptr_d;
   logic                           cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]               cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0]              cdb_data_q, cdb_data_d;
   logic [2:0]                     cdb_src_q, cdb_src_d;
   logic [3:0]                     pend_cnt_q, pend_cnt_d;

   logic [NUM_FU-1:0] gnt;
   logic [NUM_FU-1:0] fu_ready;
   logic [IW-1:0]     win_idx;
   logic              found;
   logic [IW:0]       scan_idx;
   logic [IW:0]       nxt_ptr;

   // Grant depends only on registered buffer state, never on this cycle's fu_valid.
   always_comb begin
      gnt      = '0;
      win_idx  = '0;
      found    = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (scan_idx >= NUM_FU_W) scan_idx = scan_idx - NUM_FU_W;
         if (!found && hold_v_q[scan_idx[IW-1:0]]) begin
            found                   = 1'b1;
            gnt[scan_idx[IW-1:0]]   = 1'b1;
            win_idx                 = scan_idx[IW-1:0];
         end
      end
   end

   assign fu_ready = ~hold_v_q | gnt;

   always_comb begin
      hold_v_d    = hold_v_q;
      hold_tag_d  = hold_tag_q;
      hold_data_d = hold_data_q;
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      cdb_src_d   = cdb_src_q;
      pend_cnt_d  = '0;
      nxt_ptr     = {1'b0, win_idx} + (IW+1)'(1);
      if (nxt_ptr == NUM_FU_W) nxt_ptr = '0;

      if (bus.flush) begin
         hold_v_d = '0;
      end else begin
         if (found) begin
            cdb_valid_d       = 1'b1;
            cdb_tag_d         = hold_tag_q[win_idx];
            cdb_data_d        = hold_data_q[win_idx];
            cdb_src_d         = 3'(win_idx);
            hold_v_d[win_idx] = 1'b0;
            rr_ptr_d          = nxt_ptr[IW-1:0];
         end
         // A same-cycle accept on the winner refills its buffer after the clear above.
         for (int i = 0; i < NUM_FU; i++) begin
            if (bus.fu_valid[i] && fu_ready[i]) begin
               hold_v_d[i]    = 1'b1;
               hold_tag_d[i]  = bus.fu_tag[i*TAG_W +: TAG_W];
               hold_data_d[i] = bus.fu_data[i*DATA_W +: DATA_W];
            end
         end
      end

      for (int i = 0; i < NUM_FU; i++) begin
         pend_cnt_d = pend_cnt_d + 4'(hold_v_d[i]);
      end
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         hold_v_q    <= '0;
         hold_tag_q  <= '0;
         hold_data_q <= '0;
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
         pend_cnt_q  <= '0;
      end else begin
         hold_v_q    <= hold_v_d;
         hold_tag_q  <= hold_tag_d;
         hold_data_q <= hold_data_d;
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
         pend_cnt_q  <= pend_cnt_d;
      end
   end

   assign bus.fu_ready  = fu_ready;
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_tag   = cdb_tag_q;
   assign bus.cdb_data  = cdb_data_q;
   assign bus.cdb_src   = cdb_src_q;
   assign bus.pend_cnt  = pend_cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, all checked against a
// per-unit buffer model with a rotating priority pointer.
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 3;

   logic clk1 = 1'b0;
   logic rst_n;
   always #5 clk1 = ~clk1;

   cdb_arbiter_if #(.NUM_FU(N), .DATA_W(DW), .TAG_W(TW)) bus ();
   cdb_arbiter #(.NUM_FU(N), .DATA_W(DW), .TAG_W(TW)) dut (
      .clk1  (clk1),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   bit              mv    [N];
   logic [TW-1:0]   mtag  [N];
   logic [DW-1:0]   mdata [N];
   int              mrr = 0;
   logic            e_valid = 1'b0;
   logic [TW-1:0]   e_tag   = '0;
   logic [DW-1:0]   e_data  = '0;
   logic [2:0]      e_src   = '0;
   logic [3:0]      e_pend  = '0;

   function automatic int model_winner();
      int w = -1;
      for (int off = 0; off < N; off++) begin
         int u = (mrr + off) % N;
         if (w < 0 && mv[u]) w = u;
      end
      return w;
   endfunction

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      int w = model_winner();
      for (int i = 0; i < N; i++) r[i] = !mv[i] || (i == w);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check ready before the edge, update model at the edge,
   // check registered outputs just after it.
   task automatic cycle(input bit r, input bit f, input logic [N-1:0] v,
                        input logic [N*TW-1:0] t, input logic [N*DW-1:0] d,
                        output logic [N-1:0] rdy);
      int w;
      int cnt;
      @(negedge clk1);
      rst_n        = r;
      bus.flush    = f;
      bus.fu_valid = v;
      bus.fu_tag   = t;
      bus.fu_data  = d;
      #1;
      rdy = model_ready();
      w   = model_winner();
      check("fu_ready", 64'(bus.fu_ready), 64'(rdy));
      @(posedge clk1);
      if (!r) begin
         for (int i = 0; i < N; i++) mv[i] = 1'b0;
         mrr = 0; e_valid = 1'b0; e_tag = '0; e_data = '0; e_src = '0;
      end else if (f) begin
         for (int i = 0; i < N; i++) mv[i] = 1'b0;
         e_valid = 1'b0;
      end else begin
         if (w >= 0) begin
            e_valid = 1'b1; e_tag = mtag[w]; e_data = mdata[w]; e_src = 3'(w);
            mv[w] = 1'b0;
            mrr = (w + 1) % N;
         end else begin
            e_valid = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (v[i] && rdy[i]) begin
               mv[i] = 1'b1; mtag[i] = t[i*TW +: TW]; mdata[i] = d[i*DW +: DW];
            end
         end
      end
      cnt = 0;
      for (int i = 0; i < N; i++) cnt += int'(mv[i]);
      e_pend = 4'(cnt);
      #1;
      check("cdb_valid", 64'(bus.cdb_valid), 64'(e_valid));
      check("cdb_tag",   64'(bus.cdb_tag),   64'(e_tag));
      check("cdb_data",  64'(bus.cdb_data),  64'(e_data));
      check("cdb_src",   64'(bus.cdb_src),   64'(e_src));
      check("pend_cnt",  64'(bus.pend_cnt),  64'(e_pend));
   endtask

   initial begin
      logic [N-1:0]    rdy;
      logic [N-1:0]    pv;
      logic [N*TW-1:0] pt;
      logic [N*DW-1:0] pd;
      logic [N-1:0]    v;
      bit              f, r;

      for (int i = 0; i < N; i++) begin mv[i] = 1'b0; mtag[i] = '0; mdata[i] = '0; end
      rst_n = 1'b0; bus.flush = 1'b0; bus.fu_valid = 4'hF; bus.fu_tag = '0; bus.fu_data = '0;
      @(posedge clk1);

      // Reset held with all units requesting.
      cycle(1'b0, 1'b0, 4'hF, 12'hFFF, {4{32'hDEAD_BEEF}}, rdy);
      cycle(1'b0, 1'b0, 4'hF, 12'hFFF, {4{32'hDEAD_BEEF}}, rdy);
      check("reset_ready", 64'(bus.fu_ready), 64'h0F);
      cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);
      cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);

      // Single result from unit 2.
      cycle(1'b1, 1'b0, 4'b0100, 12'(3'd5) << 6, 128'(32'h0000_00FF) << 64, rdy);
      check("single_pend1", 64'(bus.pend_cnt), 64'd1);
      cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);
      check("single_valid", 64'(bus.cdb_valid), 64'd1);
      check("single_src",   64'(bus.cdb_src),   64'd2);
      check("single_data",  64'(bus.cdb_data),  64'hFF);
      cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);
      check("single_once",  64'(bus.cdb_valid), 64'd0);

      // Unit 3 once, bringing the pointer back to 0.
      cycle(1'b1, 1'b0, 4'b1000, 12'(3'd7) << 9, 128'(32'hAB) << 96, rdy);
      cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);
      cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);

      // All four collide.
      cycle(1'b1, 1'b0, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0},
            {32'h33, 32'h22, 32'h11, 32'h00}, rdy);
      check("coll_pend", 64'(bus.pend_cnt), 64'd4);
      for (int k = 0; k < N; k++) begin
         cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);
         check("coll_src",  64'(bus.cdb_src),  64'(k));
         check("coll_pend", 64'(bus.pend_cnt), 64'(3 - k));
      end

      // Units 0 and 1 stream continuously; each retries its result until accepted.
      pt = '0; pd = '0;
      for (int i = 0; i < 2; i++) begin pt[i*TW +: TW] = 3'(i); pd[i*DW +: DW] = 32'(100 * i); end
      for (int j = 1; j <= 8; j++) begin
         cycle(1'b1, 1'b0, 4'b0011, pt, pd, rdy);
         if (j >= 2) check("alt_src", 64'(bus.cdb_src), 64'(j % 2));
         for (int i = 0; i < 2; i++) begin
            if (rdy[i]) begin
               pt[i*TW +: TW] = pt[i*TW +: TW] + 3'd2;
               pd[i*DW +: DW] = pd[i*DW +: DW] + 32'd1;
            end
         end
      end
      repeat (3) cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);

      // Flush with three buffers occupied.
      cycle(1'b1, 1'b0, 4'b0111, {3'd0, 3'd6, 3'd5, 3'd4}, {32'h0, 32'hC6, 32'hC5, 32'hC4}, rdy);
      check("flush_pre_pend", 64'(bus.pend_cnt), 64'd3);
      cycle(1'b1, 1'b1, 4'hF, 12'hFFF, {4{32'h5555_AAAA}}, rdy);
      check("flush_valid", 64'(bus.cdb_valid), 64'd0);
      check("flush_pend",  64'(bus.pend_cnt),  64'd0);
      cycle(1'b1, 1'b0, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, rdy);
      check("flush_ready", 64'(rdy), 64'h0F);
      repeat (5) cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);

      // Reset while broadcasting with two still pending.
      cycle(1'b1, 1'b0, 4'b1101, {3'd1, 3'd2, 3'd0, 3'd3}, {32'hE3, 32'hE2, 32'h0, 32'hE0}, rdy);
      cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);
      check("mid_valid", 64'(bus.cdb_valid), 64'd1);
      check("mid_pend",  64'(bus.pend_cnt),  64'd2);
      cycle(1'b0, 1'b0, 4'hF, 12'hABC, {4{32'h1234_5678}}, rdy);
      check("mid_rst_valid", 64'(bus.cdb_valid), 64'd0);
      check("mid_rst_data",  64'(bus.cdb_data),  64'd0);
      repeat (4) cycle(1'b1, 1'b0, 4'h0, '0, '0, rdy);

      // Random traffic: each unit holds its result until accepted.
      pv = '0; pt = '0; pd = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pv[i] && ($urandom % 3 != 0)) begin
               pv[i] = 1'b1;
               pt[i*TW +: TW] = 3'($urandom);
               pd[i*DW +: DW] = $urandom;
            end
         end
         f = ($urandom % 25 == 0);
         r = ($urandom % 150 != 0);
         v = pv;
         cycle(r, f, v, pt, pd, rdy);
         for (int i = 0; i < N; i++) begin
            if (v[i] && rdy[i]) pv[i] = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
